// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift_right_sched scheduler.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned OP_COUNT_W = 16;

endpackage

// File: rtl/shift_right_op.sv
// Shared logical right-shift datapath; amounts of N or more yield zero.
module shift_right_op #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out
);

  // A shift by the full unsigned amount already zero-fills past the width.
  assign out = a >> b;

endmodule

// File: rtl/shift_sched_rr_arb.sv
// Combinational round-robin pick: first valid requester after last_grant.
module shift_sched_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/shift_right_sched.sv
// Round-robin scheduler sharing one shift_right_op among NREQ requesters.
//   state   | meaning
//   IDLE    | waiting for a request; grants combinationally
//   EXEC    | operand registers drive the shifter
//   RESP    | result held on the response channel until accepted
module shift_right_sched
  import shift_sched_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*N-1:0]     req_a,
  input  logic [NREQ*N-1:0]     req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [N-1:0]          rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic [OP_COUNT_W-1:0] op_count
);

  state_e                  state_q, state_d;
  logic [IDW-1:0]          last_grant_q, last_grant_d;
  logic [N-1:0]            a_q, a_d;
  logic [N-1:0]            b_q, b_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [N-1:0]            rsp_data_q, rsp_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    busy_q, busy_d;
  logic [OP_COUNT_W-1:0]   op_count_q, op_count_d;

  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          grant_idx;
  logic                    grant_any;
  logic [N-1:0]            shift_out;

  shift_sched_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  shift_right_op #(
    .N (N)
  ) u_shift (
    .a   (a_q),
    .b   (b_q),
    .out (shift_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready    = grant;
          a_d          = req_a[int'(grant_idx)*N +: N];
          b_d          = req_b[int'(grant_idx)*N +: N];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = shift_out;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d = OP_COUNT_W'(op_count_q + 1'b1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flag outputs are registered copies of the next state.
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule
